// File: rtl/memory_arbiter.sv
// Round-robin arbiter funnelling N request masters into one registered downstream
// request slot, with a combinational ID-based response router back to the masters.
module memory_arbiter #(
    parameter int N_MASTERS     = 4,
    parameter int ID_WIDTH      = 2,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 24
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_MASTERS*ADDRESS_WIDTH-1:0] mAddress,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]    mData,
    input  logic [N_MASTERS-1:0]               mWrite,
    input  logic [N_MASTERS-1:0]               mValid,
    output logic [N_MASTERS-1:0]               mTaken,
    output logic [ID_WIDTH-1:0]                msID,
    output logic [ADDRESS_WIDTH-1:0]           msAddress,
    output logic [DATA_WIDTH-1:0]              msData,
    output logic                               msWrite,
    output logic                               msValid,
    input  logic                               msTaken,
    input  logic [ID_WIDTH-1:0]                smID,
    input  logic [DATA_WIDTH-1:0]              smData,
    input  logic                               smValid,
    output logic                               smTaken,
    output logic [N_MASTERS*DATA_WIDTH-1:0]    sData,
    output logic [N_MASTERS-1:0]               sValid,
    input  logic [N_MASTERS-1:0]               sTaken
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   nextPtr;
    logic                  found;
    logic                  loadable;
    int                    idx;

    assign loadable = (state == EMPTY) || msTaken;
    assign msValid  = (state == FULL);

    // Scan masters starting at ptr, wrapping, and keep the first requester seen.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_MASTERS)
                idx = idx - N_MASTERS;
            if (!found && mValid[idx]) begin
                found  = 1'b1;
                winner = ID_WIDTH'(idx);
            end
        end
    end

    assign nextPtr = (int'(winner) == N_MASTERS - 1) ? '0 : winner + 1'b1;

    // Accept goes out only when the slot can actually take the beat this cycle.
    always_comb begin
        mTaken = '0;
        if (!reset && loadable && found)
            mTaken[winner] = 1'b1;
    end

    // Output slot: a new winner overwrites a draining entry with no bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= EMPTY;
            ptr       <= '0;
            msID      <= '0;
            msAddress <= '0;
            msData    <= '0;
            msWrite   <= 1'b0;
        end else if (loadable) begin
            if (found) begin
                state     <= FULL;
                ptr       <= nextPtr;
                msID      <= winner;
                msAddress <= mAddress[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                msData    <= mData[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                msWrite   <= mWrite[winner];
            end else begin
                state <= EMPTY;
            end
        end
    end

    // IDs outside the master range (non power-of-two counts) are swallowed.
    always_comb begin
        sData   = {N_MASTERS{smData}};
        sValid  = '0;
        smTaken = 1'b1;
        if (int'(smID) < N_MASTERS) begin
            sValid[smID] = smValid;
            smTaken      = sTaken[smID];
        end
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 4, number of requesting masters (2..16).
REQ-002 SHALL have parameter ID_WIDTH, default 2, width of the master ID; ID_WIDTH = clog2(N_MASTERS).
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32, request address width.
REQ-004 SHALL have parameter DATA_WIDTH, default 24, request and response data width.
REQ-005 SHALL have ports: clock  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports mAddress/mData/mWrite/mValid  in  N_MASTERS x (ADDRESS_WIDTH/DATA_WIDTH/1/1), packed  per-master requests; master i occupies slice i.
REQ-008 SHALL have port mTaken  out  N_MASTERS  per-master request accept.
REQ-009 SHALL have ports msID/msAddress/msData/msWrite/msValid  out  ID_WIDTH/ADDRESS_WIDTH/DATA_WIDTH/1/1  downstream request.
REQ-010 SHALL have port msTaken  in  1  downstream request accept.
REQ-011 SHALL have ports smID/smData/smValid  in  ID_WIDTH/DATA_WIDTH/1  downstream response.
REQ-012 SHALL have port smTaken  out  1  response accept.
REQ-013 SHALL have ports sData/sValid  out  N_MASTERS x DATA_WIDTH / N_MASTERS  per-master responses; sTaken  in  N_MASTERS  per-master response accept.

Function
REQ-014 SHALL transfer a beat on any valid/taken pair only when both are 1 in the same cycle.
REQ-015 SHALL hold one output request register (state EMPTY or FULL); msValid = FULL.
REQ-016 SHALL treat the register as loadable in a cycle when EMPTY, or FULL with msTaken=1.
REQ-017 SHALL, when loadable and any mValid=1, pick the winner by round-robin from pointer ptr: first i in ptr, ptr+1, ... (mod N_MASTERS) with mValid[i]=1.
REQ-018 SHALL assert mTaken[winner]=1 combinationally in that cycle, all other mTaken=0, and capture that master's address, data, write, plus msID=winner, at the next edge.
REQ-019 SHALL set ptr to (winner+1) mod N_MASTERS after each grant; ptr is unchanged when no grant.
REQ-020 SHALL drive all mTaken=0 when not loadable.
REQ-021 SHALL, when FULL, msTaken=1 and a new winner exist, replace the register contents without a bubble (back-to-back, one request per cycle sustained).
REQ-022 SHALL go to EMPTY when FULL, msTaken=1 and no mValid is set.
REQ-023 SHALL hold msID/msAddress/msData/msWrite stable while msValid=1 and msTaken=0.
REQ-024 SHALL have request latency of exactly 1 cycle, from the mTaken beat to msValid.
REQ-025 SHALL route responses combinationally: if smID < N_MASTERS, then sValid[smID]=smValid, sData[all]=smData, and smTaken=sTaken[smID]; all other sValid=0.
REQ-026 SHALL, for smID >= N_MASTERS (only when N_MASTERS is not a power of 2), drive smTaken=1 and all sValid=0 (drop).
REQ-027 SHALL keep request and response paths independent; a response to master i and a grant to master i may occur in the same cycle.
REQ-028 SHALL never grant more than one master per cycle, and never starve a master holding mValid=1 beyond N_MASTERS grants.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, set state EMPTY, ptr=0, msValid=0, msID=0, msAddress=0, msData=0, msWrite=0.
REQ-030 SHALL drive all mTaken=0 during a cycle with reset=1; response routing remains combinational.
REQ-031 SHALL discard a FULL register asserted mid-transfer when reset is applied; the master already saw mTaken and is not re-granted.

Verification
REQ-032 Single request: mValid[2]=1, addr 0x100, data 0xABCDEF, write=1, msTaken=1 -> mTaken[2] cycle 0; cycle 1 msValid=1, msID=2, msAddress=0x100, msData=0xABCDEF, msWrite=1.
REQ-033 Round robin: mValid=4'b1111 held, msTaken=1 -> grants 0,1,2,3,0 on consecutive cycles; msValid continuous from cycle 1.
REQ-034 Backpressure: FULL with msID=1, msTaken=0 for 5 cycles, mValid[3]=1 -> mTaken all 0, msAddress stable; msTaken=1 -> mTaken[3]=1 same cycle, msID=3 next cycle.
REQ-035 Response routing: smID=3, smValid=1, smData=0x123456, sTaken[3]=0 then 1 -> sValid=4'b1000, smTaken 0 then 1; sValid[0..2]=0 throughout.
REQ-036 Reset mid-operation: FULL, ptr=2, reset=1 one cycle -> msValid=0, ptr=0; then mValid=4'b0110 -> master 1 granted first.
REQ-037 Invalid ID: N_MASTERS=3, smID=3, smValid=1 -> smTaken=1, sValid=3'b000.
